sw_debounce: RTL and testbench
==============================

Name: sw_debounce

Overview:
- Conditions the raw slide-switch pins (SW[3:0]) before they reach the soc_system `sw` PIO input on the lightweight HPS-to-FPGA bus.
- Synchronises each pin to clk, then debounces it per bit with a stability counter.
- Publishes a clean debounced vector plus one-cycle change pulses.
- Sits directly upstream of the PIO export. Linux therefore sees one transition per physical flip, never bounce.

Parameters:
- WIDTH, 4: number of switch bits.
- CLK_HZ, 50000000: clk frequency in Hz.
- DEBOUNCE_US, 10000: required stable time in microseconds.
- SYNC_STAGES, 2: synchroniser depth, minimum 2.
- Derived: CNT_MAX = (CLK_HZ/1000000)*DEBOUNCE_US. Elaboration error if CNT_MAX < 2 or SYNC_STAGES < 2.

Ports:
- clk  in  1  system clock, FPGA_CLK1_50 domain.
- reset  in  1  asynchronous, active-high reset.
- sw_in  in  WIDTH  raw asynchronous switch pins.
- sw_out  out  WIDTH  debounced switch state; feeds sw_export.
- sw_change  out  WIDTH  one-cycle pulse per bit on each accepted transition.
- sw_valid  out  1  high once the initial state is qualified; stays high until reset.

Behaviour:
- Reset (async assert, sync release by system):
  - sync flops, counters, sw_out, sw_change and sw_valid all go to 0.
  - FSM goes to INIT.
- Synchroniser: SYNC_STAGES flops per bit. s = last stage.
- FSM INIT:
  - A global counter g increments while s is equal to s of the previous cycle.
  - Any bit change in s clears g to 0.
  - When g reaches CNT_MAX-1, the next cycle loads sw_out <= s and sets sw_valid=1, with no sw_change pulse. The FSM then goes to RUN.
  - sw_out stays 0 throughout INIT.
- FSM RUN, per bit i independently, with counter c[i] of width clog2(CNT_MAX):
  - s[i]==sw_out[i]: c[i] <= 0.
  - s[i]!=sw_out[i] and c[i]<CNT_MAX-1: c[i] increments.
  - s[i]!=sw_out[i] and c[i]==CNT_MAX-1: sw_out[i] toggles, sw_change[i]=1 for exactly that cycle, c[i] <= 0.
- Latency: pin edge to sw_out change = SYNC_STAGES + CNT_MAX cycles. sw_change asserts in the same cycle sw_out updates.
- Glitch rejection: any excursion lasting fewer than CNT_MAX synchronised cycles produces no output change, and the counter restarts.
- Simultaneous bit changes: bits are fully independent; several sw_change bits may pulse in the same cycle.
- Counter saturation cannot occur: the counter is cleared on the toggle.
- Reset mid-count: all progress is discarded and the FSM re-enters INIT.
- Outputs are registered; there is no combinational path from sw_in.

Optional Feature:
- Macro: SW_DEBOUNCE_LATCH_EN.
- Defined:
  - Adds input sw_event_clr[WIDTH] and output sw_event[WIDTH]. sw_event is a sticky register, reset 0.
  - sw_event[i] is set by sw_change[i] and cleared by sw_event_clr[i] (one-cycle pulse).
  - Same-cycle set and clear: set wins.
  - Visible one cycle after sw_change.
- Undefined: the ports and register are absent; behaviour is otherwise identical.

Decomposition:
- Package sw_debounce_pkg:
  - FSM state enum {INIT, RUN}.
  - Function to compute CNT_MAX from CLK_HZ/DEBOUNCE_US.
  - Counter width constant helper.
- Sub-module sw_debounce_bit: synchroniser, counter and toggle logic for one bit. Instantiated WIDTH times via generate, with a run enable from the top FSM.
- Top level owns the INIT FSM, the g counter, sw_valid, and the optional latch.

Test Plan (CLK_HZ=1000000, DEBOUNCE_US=8, so CNT_MAX=8; WIDTH=4; SYNC_STAGES=2):
- Power-up, sw_in=4'b1010 held stable. Required: sw_valid rises and sw_out=4'b1010 at cycle 2+8 after reset release, with no sw_change pulse.
- In RUN, bit0 0->1 held. Required: sw_out[0]=1 and sw_change=4'b0001 for one cycle, exactly 10 cycles after the edge.
- Bounce: bit1 toggles high for 7 cycles, low for 1, then high. Required: the first 7-cycle excursion is rejected, and sw_out[1] rises 10 cycles after the final rising edge.
- bits 2 and 3 change in the same cycle. Required: sw_change=4'b1100 in a single cycle.
- reset asserted at count 5 of a pending bit0 change, then released. Required: outputs go 0 immediately (asynchronously), INIT re-qualifies, and no sw_change pulse occurs.
- With SW_DEBOUNCE_LATCH_EN, bit0 change followed by sw_event_clr=4'b0001 in the set cycle. Required: sw_event[0]=1 (set wins); the next clear pulse returns it to 0.

Source files
------------

// File: rtl/sw_debounce_pkg.sv
// Shared types and elaboration helpers for the slide-switch debouncer.
// Used by sw_debounce and sw_debounce_bit.
package sw_debounce_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Whole-MHz clock assumed: the sub-MHz remainder of clk_hz is dropped.
  function automatic int calc_cnt_max(input int clk_hz, input int debounce_us);
    return (clk_hz / 1000000) * debounce_us;
  endfunction

  function automatic int cnt_width(input int cnt_max);
    return (cnt_max < 2) ? 1 : $clog2(cnt_max);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: multi-flop synchroniser, stability counter and toggle.
// i_load captures the synchronised level at the end of qualification.
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_MAX     = 8,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  input  logic i_run,
  input  logic i_load,
  output logic o_sync,
  output logic o_sync_next,
  output logic o_out,
  output logic o_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_out;
  logic                   r_change;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_out    <= 1'b0;
      r_change <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_change <= 1'b0;
      if (i_load) begin
        r_out <= w_s;
        r_cnt <= '0;
      end else if (!i_run || (w_s == r_out)) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Clearing on the toggle is what keeps the counter from ever saturating.
        r_out    <= ~r_out;
        r_change <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_sync      = w_s;
  assign o_sync_next = r_sync[SYNC_STAGES-2];
  assign o_out       = r_out;
  assign o_change    = r_change;

endmodule

// File: rtl/sw_debounce.sv
// Debounced slide-switch conditioner feeding the sw PIO export.
// Optional sticky event latch: define SW_DEBOUNCE_LATCH_EN.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CLK_HZ      = 50000000,
  parameter int DEBOUNCE_US = 10000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_change,
  output logic             sw_valid
`ifdef SW_DEBOUNCE_LATCH_EN
  ,
  input  logic [WIDTH-1:0] sw_event_clr,
  output logic [WIDTH-1:0] sw_event
`endif
);

  localparam int CNT_MAX = calc_cnt_max(CLK_HZ, DEBOUNCE_US);
  localparam int CNT_W   = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(CNT_MAX - 1);

  if (CNT_MAX < 2 || SYNC_STAGES < 2) begin : g_param_check
    $error("sw_debounce: CNT_MAX and SYNC_STAGES must both be at least 2");
  end

  state_e           r_state;
  logic [CNT_W-1:0] r_g;
  logic             r_valid;
  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_s_next;
  logic [WIDTH-1:0] w_out;
  logic [WIDTH-1:0] w_change;
  logic             w_run;
  logic             w_load;
  logic             w_stable;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      sw_debounce_bit #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_MAX    (CNT_MAX),
        .CNT_W      (CNT_W)
      ) u_bit (
        .clk        (clk),
        .reset      (reset),
        .i_pin      (sw_in[gi]),
        .i_run      (w_run),
        .i_load     (w_load),
        .o_sync     (w_s[gi]),
        .o_sync_next(w_s_next[gi]),
        .o_out      (w_out[gi]),
        .o_change   (w_change[gi])
      );
    end
  endgenerate

  // Peeking at the stage before s lets g describe the cycle s is entering, so
  // qualification ends SYNC_STAGES + CNT_MAX cycles after the pins settle.
  assign w_stable = (w_s_next == w_s);
  assign w_run    = (r_state == RUN);
  assign w_load   = (r_state == INIT) && (r_g == G_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT;
      r_g     <= '0;
      r_valid <= 1'b0;
    end else if (r_state == INIT) begin
      if (w_load) begin
        r_state <= RUN;
        r_valid <= 1'b1;
        r_g     <= '0;
      end else if (w_stable) begin
        r_g <= r_g + CNT_W'(1);
      end else begin
        r_g <= '0;
      end
    end else begin
      r_g <= '0;
    end
  end

  assign sw_out    = w_out;
  assign sw_change = w_change;
  assign sw_valid  = r_valid;

`ifdef SW_DEBOUNCE_LATCH_EN
  logic [WIDTH-1:0] r_event;

  // A set arriving with a clear for the same bit wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_event <= '0;
    end else begin
      r_event <= (r_event & ~sw_event_clr) | w_change;
    end
  end

  assign sw_event = r_event;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Randomised self-checking bench for sw_debounce against a sample-history model.
// Also exercises the sticky event latch when SW_DEBOUNCE_LATCH_EN is defined.
module tb_sw_debounce;

  localparam int WIDTH       = 4;
  localparam int CLK_HZ      = 1000000;
  localparam int DEBOUNCE_US = 8;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_MAX     = (CLK_HZ / 1000000) * DEBOUNCE_US;
  localparam int LAT         = SYNC_STAGES + CNT_MAX;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_change;
  logic             sw_valid;
  logic [WIDTH-1:0] clr_drv;
`ifdef SW_DEBOUNCE_LATCH_EN
  logic [WIDTH-1:0] sw_event;
`endif

  sw_debounce #(
    .WIDTH      (WIDTH),
    .CLK_HZ     (CLK_HZ),
    .DEBOUNCE_US(DEBOUNCE_US),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_in    (sw_in),
    .sw_out   (sw_out),
    .sw_change(sw_change),
    .sw_valid (sw_valid)
`ifdef SW_DEBOUNCE_LATCH_EN
    ,
    .sw_event_clr(clr_drv),
    .sw_event    (sw_event)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Model: in_hist[k] is the pin value sampled at edge k (index 0 = reset),
  // s_hist[k] the synchronised value during cycle k.
  logic [WIDTH-1:0] in_hist[$];
  logic [WIDTH-1:0] s_hist[$];
  logic [WIDTH-1:0] m_out;
  logic [WIDTH-1:0] m_chg;
  logic [WIDTH-1:0] m_ev;
  logic             m_valid;
  int               k;

  task automatic model_reset();
    in_hist = {};
    s_hist  = {};
    in_hist.push_back('0);
    s_hist.push_back('0);
    m_out   = '0;
    m_chg   = '0;
    m_ev    = '0;
    m_valid = 1'b0;
    k       = 0;
  endtask

  // Output moves once the last CNT_MAX synchronised samples all agree (INIT)
  // or all disagree with the current output bit (RUN).
  task automatic model_step(input logic [WIDTH-1:0] in_now, input logic [WIDTH-1:0] clr_now);
    logic [WIDTH-1:0] s_new;
    bit               all_eq;
    bit               all_diff;
    k++;
    m_ev  = (m_ev & ~clr_now) | m_chg;
    m_chg = '0;
    if (k >= CNT_MAX) begin
      if (!m_valid) begin
        all_eq = 1'b1;
        for (int j = k - CNT_MAX; j < k; j++)
          if (s_hist[j] != s_hist[k-1]) all_eq = 1'b0;
        if (all_eq) begin
          m_out   = s_hist[k-1];
          m_valid = 1'b1;
        end
      end else begin
        for (int b = 0; b < WIDTH; b++) begin
          all_diff = 1'b1;
          for (int j = k - CNT_MAX; j < k; j++)
            if (s_hist[j][b] == m_out[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_out[b] = ~m_out[b];
            m_chg[b] = 1'b1;
          end
        end
      end
    end
    in_hist.push_back(in_now);
    s_new = (k - SYNC_STAGES + 1 >= 0) ? in_hist[k-SYNC_STAGES+1] : '0;
    s_hist.push_back(s_new);
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic tick(input logic [WIDTH-1:0] v, input logic [WIDTH-1:0] clr);
    sw_in   = v;
    clr_drv = clr;
    @(posedge clk);
    #1;
    model_step(v, clr);
    check("sw_out", 32'(sw_out), 32'(m_out));
    check("sw_change", 32'(sw_change), 32'(m_chg));
    check("sw_valid", 32'(sw_valid), 32'(m_valid));
`ifdef SW_DEBOUNCE_LATCH_EN
    check("sw_event", 32'(sw_event), 32'(m_ev));
`endif
    @(negedge clk);
  endtask

  task automatic run_until_change(input logic [WIDTH-1:0] v, input int max_ticks,
                                  output int idx, output logic [WIDTH-1:0] chg);
    idx = -1;
    chg = '0;
    for (int t = 1; t <= max_ticks; t++) begin
      tick(v, '0);
      if (idx < 0 && sw_change != '0) begin
        idx = t;
        chg = sw_change;
      end
    end
  endtask

  task automatic qualify(input string tag, input logic [WIDTH-1:0] v);
    int               idx;
    logic [WIDTH-1:0] seen;
    idx  = -1;
    seen = '0;
    for (int t = 1; t <= LAT + 10; t++) begin
      tick(v, '0);
      seen |= sw_change;
      if (idx < 0 && sw_valid) begin
        idx = t;
        check({tag, "_out"}, 32'(sw_out), 32'(v));
      end
    end
    check({tag, "_latency"}, 32'(idx), 32'(LAT));
    check({tag, "_nochg"}, 32'(seen), 32'(0));
    $display("%s: valid after %0d cycles, sw_out=%b", tag, idx, sw_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int               idx;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] v2;
    logic [WIDTH-1:0] seen;

    reset   = 1'b1;
    sw_in   = '0;
    clr_drv = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", 32'(sw_out), 32'(0));
    check("rst_chg", 32'(sw_change), 32'(0));
    check("rst_valid", 32'(sw_valid), 32'(0));
    reset = 1'b0;

    qualify("powerup", 4'b1010);

    run_until_change(4'b1011, LAT + 4, idx, chg);
    check("bit0_latency", 32'(idx), 32'(LAT));
    check("bit0_chg", 32'(chg), 32'(4'b0001));
    $display("bit0 rise: change at cycle %0d, sw_change=%b", idx, chg);

    run_until_change(4'b1001, LAT + 4, idx, chg);
    check("bit1_fall_chg", 32'(chg), 32'(4'b0010));
    seen = '0;
    for (int t = 0; t < CNT_MAX - 1; t++) begin
      tick(4'b1011, '0);
      seen |= sw_change;
    end
    tick(4'b1001, '0);
    seen |= sw_change;
    check("bounce_reject", 32'(seen), 32'(0));
    run_until_change(4'b1011, LAT + 4, idx, chg);
    check("bounce_latency", 32'(idx), 32'(LAT));
    check("bounce_chg", 32'(chg), 32'(4'b0010));
    $display("bit1 bounce: excursion rejected, change at cycle %0d", idx);

    run_until_change(4'b0111, LAT + 4, idx, chg);
    check("dual_latency", 32'(idx), 32'(LAT));
    check("dual_chg", 32'(chg), 32'(4'b1100));
    $display("bits 2/3 together: change at cycle %0d, sw_change=%b", idx, chg);

`ifdef SW_DEBOUNCE_LATCH_EN
    for (int t = 0; t < LAT; t++) tick(4'b0110, '0);
    check("latch_chg", 32'(sw_change), 32'(4'b0001));
    tick(4'b0110, 4'b0001);
    check("latch_set_wins", 32'(sw_event[0]), 32'(1));
    tick(4'b0110, 4'b0001);
    check("latch_clear", 32'(sw_event[0]), 32'(0));
    tick(4'b0110, '0);
    $display("event latch: set beat clear, second clear removed event");
`else
    run_until_change(4'b0110, LAT + 4, idx, chg);
    check("bit0_fall_chg", 32'(chg), 32'(4'b0001));
    $display("bit0 fall: change at cycle %0d", idx);
`endif

    v = 4'b0110;
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 5) == 0) v = v ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      tick(v, ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0);
    end
    $display("random phase: %0d cycles done, sw_out=%b", 800, sw_out);

    v = 4'b1100;
    for (int t = 0; t < LAT + 2; t++) tick(v, '0);
    v2 = v ^ 4'b0001;
    for (int t = 0; t < SYNC_STAGES + 5; t++) tick(v2, '0);
    reset = 1'b1;
    #1;
    check("midrst_out", 32'(sw_out), 32'(0));
    check("midrst_chg", 32'(sw_change), 32'(0));
    check("midrst_valid", 32'(sw_valid), 32'(0));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midrst_hold_out", 32'(sw_out), 32'(0));
    model_reset();
    reset = 1'b0;
    qualify("requalify", v2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
